// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-read-port register file with write forwarding, zero entry and pending scoreboard
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   rd_addr, rd_data    packed read addresses / registered read data (port i at slice i)
//   rd_pend             registered pending flag per read port
//   wr_en/addr/data     write port; a write clears the entry's pending bit
//   rsv_en, rsv_addr    mark an entry pending (a newer producer wins over a same-edge write)
//   pend_any            OR of all pending bits
module reg_file_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_READ = 2,
    parameter int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_READ*ADDR_W-1:0] rd_addr,
    output logic [NUM_READ*WIDTH-1:0]  rd_data,
    output logic [NUM_READ-1:0]        rd_pend,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic                       pend_any
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] pend, pend_nxt;
    logic             wr_ok;
    assign wr_ok    = wr_en && wr_addr != '0;
    assign pend_any = |pend;
    always_comb begin
        pend_nxt = pend;
        if (wr_ok) pend_nxt[wr_addr] = 1'b0;
        if (rsv_en && rsv_addr != '0) pend_nxt[rsv_addr] = 1'b1;
    end
    // entry 0 is zeroed by reset and never written, so reads of it return 0 without a special case
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
            pend    <= '0;
            rd_data <= '0;
            rd_pend <= '0;
        end else begin
            if (wr_ok) mem[wr_addr] <= wr_data;
            pend <= pend_nxt;
            for (int i = 0; i < NUM_READ; i++) begin
                rd_data[i*WIDTH +: WIDTH] <= (wr_ok && wr_addr == rd_addr[i*ADDR_W +: ADDR_W]) ? wr_data : mem[rd_addr[i*ADDR_W +: ADDR_W]];
                rd_pend[i] <= (wr_ok && wr_addr == rd_addr[i*ADDR_W +: ADDR_W]) ? 1'b0 : pend[rd_addr[i*ADDR_W +: ADDR_W]];
            end
        end
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: randomized check of reg_file_mp against an array-based reference model
module tb_reg_file_mp;
    localparam int W = 32, D = 32, NR = 2, AW = 5;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR*AW-1:0]  rd_addr = '0;
    logic [NR*W-1:0]   rd_data;
    logic [NR-1:0]     rd_pend;
    logic              wr_en = 1'b0;
    logic [AW-1:0]     wr_addr = '0;
    logic [W-1:0]      wr_data = '0;
    logic              rsv_en = 1'b0;
    logic [AW-1:0]     rsv_addr = '0;
    logic              pend_any;
    logic [W-1:0]      m [D];
    logic              p [D];
    int                n_tests = 0, n_fail = 0;

    reg_file_mp #(.WIDTH(W), .DEPTH(D), .NUM_READ(NR)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend_any(pend_any)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                       input logic re, input logic [AW-1:0] ra, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        logic [NR*W-1:0] ed;
        logic [NR-1:0]   ep;
        logic            any;
        logic [AW-1:0]   a;
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd; rsv_en = re; rsv_addr = ra;
        rd_addr = {a1, a0};
        for (int i = 0; i < NR; i++) begin
            a = (i == 0) ? a0 : a1;
            if (r) begin
                ed[i*W +: W] = '0; ep[i] = 1'b0;
            end else if (we && wa == a && a != 0) begin
                ed[i*W +: W] = wd; ep[i] = 1'b0;
            end else begin
                ed[i*W +: W] = m[a]; ep[i] = p[a];
            end
        end
        if (r) begin
            for (int k = 0; k < D; k++) begin m[k] = '0; p[k] = 1'b0; end
        end else begin
            if (we && wa != 0) begin m[wa] = wd; p[wa] = 1'b0; end
            if (re && ra != 0) p[ra] = 1'b1;
        end
        any = 1'b0;
        for (int k = 0; k < D; k++) any |= p[k];
        @(posedge clk);
        #1;
        chk("rd_data", 64'(rd_data), 64'(ed));
        chk("rd_pend", 64'(rd_pend), 64'(ep));
        chk("pend_any", 64'(pend_any), 64'(any));
    endtask

    initial begin
        for (int k = 0; k < D; k++) begin m[k] = '0; p[k] = 1'b0; end
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 2);
        chk("reset_data", 64'(rd_data), 64'd0);
        chk("reset_pend", 64'(rd_pend), 64'd0);
        chk("reset_any", 64'(pend_any), 64'd0);
        cyc(0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 0);
        chk("fwd_r5", 64'(rd_data[31:0]), 64'hDEADBEEF);
        cyc(0, 0, 0, 0, 0, 0, 5, 0);
        chk("mem_r5", 64'(rd_data[31:0]), 64'hDEADBEEF);
        cyc(0, 1, 0, 32'h12345678, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("r0_data", 64'(rd_data), 64'd0);
        chk("r0_pend", 64'(rd_pend), 64'd0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        chk("r0_rsv_any", 64'(pend_any), 64'd0);
        cyc(0, 0, 0, 0, 1, 7, 0, 7);
        chk("rsv_same_edge", 64'(rd_pend[1]), 64'd0);
        chk("rsv_any", 64'(pend_any), 64'd1);
        cyc(0, 0, 0, 0, 0, 0, 0, 7);
        chk("rsv_next_edge", 64'(rd_pend[1]), 64'd1);
        cyc(0, 1, 7, 32'hA5, 0, 0, 7, 7);
        chk("clr_fwd_data", 64'(rd_data[63:32]), 64'hA5);
        chk("clr_fwd_pend", 64'(rd_pend), 64'd0);
        chk("clr_any", 64'(pend_any), 64'd0);
        cyc(0, 1, 9, 32'h55, 1, 9, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 9, 9);
        chk("rsv_wr_data", 64'(rd_data), {32'h55, 32'h55});
        chk("rsv_wr_pend", 64'(rd_pend), 64'd3);
        cyc(0, 1, 3, 32'h1, 1, 4, 0, 0);
        cyc(1, 1, 3, 32'h2, 0, 0, 3, 4);
        cyc(0, 0, 0, 0, 0, 0, 3, 4);
        chk("rst_r3_data", 64'(rd_data[31:0]), 64'd0);
        chk("rst_r4_pend", 64'(rd_pend[1]), 64'd0);
        chk("rst_any", 64'(pend_any), 64'd0);
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 99) == 0), 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 9) == 0 ? $urandom : $urandom_range(0, 7)),
                5'($urandom_range(0, 7)));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file for the pipelined MIPS datapath. It has one write port and NUM_READ read ports, with registered reads and same-edge write-to-read forwarding. Entry 0 is hardwired to zero. A per-entry pending scoreboard lets the decode stage detect operands whose producing instruction has not yet written back. The block sits between decode (reads, reservations) and write-back (writes).

## Interface
Parameters:
- WIDTH, 32, data width of each entry
- DEPTH, 32, number of entries (power of two, ≥2)
- NUM_READ, 2, number of read ports (1..4)
- ADDR_W, $clog2(DEPTH), address width (derived; do not override)

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  reset, synchronous, active-high
- rd_addr  in  NUM_READ*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_READ*WIDTH  packed registered read data, same packing
- rd_pend  out  NUM_READ  registered pending flag per read port
- wr_en  in  1  write enable
- wr_addr  in  ADDR_W  write address
- wr_data  in  WIDTH  write data
- rsv_en  in  1  reserve (mark pending) enable
- rsv_addr  in  ADDR_W  entry to mark pending
- pend_any  out  1  OR of all pending bits (registered state, no extra latency)

## Operation
- State: mem[0..DEPTH-1] (WIDTH bits each) and pend[0..DEPTH-1] (1 bit each).
- Entry 0: a write or reserve to it is ignored. mem[0] and pend[0] are always 0. A read of address 0 returns data 0 and pending 0.
- Write: if wr_en and wr_addr≠0, mem[wr_addr] ← wr_data at the edge. The same edge clears pend[wr_addr].
- Reserve: if rsv_en and rsv_addr≠0, the edge sets pend[rsv_addr].
- Reserve and write to the same address at the same edge: pend ends at 1, because the newer producer wins. mem still takes wr_data.
- Read port i, at every edge, is evaluated independently per port; ports may share an address:
  - rd_data[i] ← wr_data if wr_en, wr_addr==rd_addr[i] and wr_addr≠0; otherwise mem[rd_addr[i]] (old value).
  - rd_pend[i] ← 0 if that same forwarding condition holds; otherwise pend[rd_addr[i]] before this edge's reserve. A same-edge reserve is never visible on the same read.
- Reset has priority over wr_en and rsv_en at the same edge. While rst=1 at an edge:
  - all mem entries ← 0, all pend ← 0
  - rd_data ← 0, rd_pend ← 0
  - the write and reserve at that edge are discarded
- Outputs after reset: rd_data=0, rd_pend=0, pend_any=0.
- Address out of range cannot occur, because DEPTH is a power of two. All arithmetic is unsigned compare only.

## Timing
- Read latency: 1 cycle. An address presented before edge N appears on rd_data/rd_pend after edge N and holds until edge N+1.
- Write latency: a write at edge N is visible through forwarding on reads sampled at edge N. It is visible from mem for reads sampled at edge N+1 onward.
- Reserve at edge N: visible on rd_pend for reads sampled at edge N+1 onward. Visible on pend_any right after edge N.
- Clear-by-write at edge N: rd_pend=0 for reads sampled at edge N (by forwarding) and after.
- No handshake and no stall: every input is accepted every cycle.
- Reset mid-operation: a reset asserted at any cycle zeroes all state at that edge. Reservations outstanding before the reset are lost, with no drain.

## Test plan
- Reset, then read addrs (1,2) -> rd_data=(0,0), rd_pend=(0,0), pend_any=0.
- Write 0xDEADBEEF to r5 and read r5 on port 0 at the same edge -> port 0 shows 0xDEADBEEF the next cycle (forwarded). Read again one cycle later -> still 0xDEADBEEF from mem.
- Write 0x12345678 to r0, then read r0 on all ports -> data 0, pend 0. Reserve r0 -> pend_any stays 0.
- Reserve r7 at edge N with port 1 reading r7 at edge N -> rd_pend[1]=0. Read at edge N+1 -> rd_pend[1]=1, pend_any=1. Write r7=0xA5 at edge N+2 while reading r7 -> rd_data=0xA5, rd_pend=0.
- Reserve and write r9 (0x55) at the same edge -> pend[9]=1 and mem[9]=0x55. A later read shows 0x55 with pend 1.
- Write r3=0x1 and reserve r4, then assert rst together with a write r3=0x2 -> after that edge r3 reads 0, r4 pend 0, and the discarded write does not appear on later reads.
